mux_arb_nx: RTL and testbench
=============================

Name: mux_arb_nx

Overview:
- Parametrised successor to the fixed 2:1 select muxes in the datapath.
- Selects one of CH requesting channels, each WIDTH bits wide, using valid/ready handshakes.
- Arbitration is fixed-priority or round-robin.
- The winner is captured in a one-entry output register, with full back-pressure support.
- Used where several producers share one consumer port, e.g. writeback or memory-request merging in the multi-cycle core.

Parameters:
- WIDTH, 32, data width per channel in bits (>=1).
- CH, 4, number of input channels (>=1; need not be a power of two).
- SELW, clog2(CH) with minimum 1, width of the channel index. Derived; never overridden.

Ports:
- clk  input  1  rising-edge clock
- clrn  input  1  synchronous active-low reset
- mode  input  1  0 = fixed priority (lowest index wins); 1 = round-robin
- in_valid  input  CH  per-channel request; bit i belongs to channel i
- in_data  input  CH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- in_ready  output  CH  per-channel accept, one-hot or zero
- out_valid  output  1  output register holds a word
- out_data  output  WIDTH  selected word
- out_sel  output  SELW  index of the channel that supplied out_data
- out_ready  input  1  consumer accepts the output word

Behaviour:
- Single clock domain: clk. Reset is synchronous, active-low, on clrn. All state updates on the rising edge of clk.
- Reset (clrn=0 at a clock edge) forces:
  - out_valid=0, out_data=0, out_sel=0
  - round-robin pointer ptr=0
  - while clrn=0, in_ready is held at all zeros.
- Internal state:
  - Output register: out_valid, out_data, out_sel.
  - ptr in range [0, CH-1].
- load = clrn & (~out_valid | out_ready). The register may accept a new word this cycle.
- Grant (combinational, one-hot or zero):
  - mode=0: lowest index i with in_valid[i]=1.
  - mode=1: first i with in_valid[i]=1, searching ptr, ptr+1, ..., CH-1, 0, ..., ptr-1.
  - No valid inputs: grant=0.
- in_ready[i] = load & grant[i]. It never depends on in_valid of other channels beyond the grant logic.
- A transfer on channel i occurs when in_valid[i] & in_ready[i]. On that edge:
  - out_data <= in_data[i], out_sel <= i, out_valid <= 1.
- load=1 with no grant: out_valid <= 0; out_data and out_sel hold their values.
- load=0 (out_valid=1 and out_ready=0): out_valid, out_data and out_sel hold stable. All in_ready=0.
- Latency and throughput:
  - 1 cycle from input transfer to out_valid.
  - Full throughput of 1 word per cycle when out_ready is held at 1.
- Pointer update, on a transfer from channel g:
  - mode=1: ptr <= (g==CH-1) ? 0 : g+1. Wraps at CH-1, not at 2^SELW.
  - mode=0: ptr holds.
  - Changing mode takes effect in the same cycle. Round-robin resumes from the held ptr.
- Simultaneous drain and load (out_valid=1, out_ready=1, grant present) is a bubble-free replace in one edge.
- Input assumption: once asserted, in_valid/in_data stay stable until accepted. The block does not check this.
- CH=1: grant = in_valid[0], out_sel is always 0, ptr stays 0.
- Reset mid-operation discards the held word; no transfer is reported on that edge.
- out_data/out_sel must not change while out_valid=1 and out_ready=0.

Test Plan:
- Reset, then idle: clrn=0 for 2 cycles, then release with all in_valid=0 → out_valid=0, out_data=0, out_sel=0, in_ready=0 every cycle.
- Fixed priority (mode=0, CH=4, out_ready=1): all four channels valid with data 0xA0..0xA3 held for 4 cycles → out_sel=0 each cycle, out_data=0xA0, in_ready=4'b0001; ptr unchanged.
- Round-robin (mode=1): all valid continuously, data 0x10+i → out_sel sequence 0,1,2,3,0,1, one word per cycle, no bubbles.
- Back-pressure: out_ready=0 for 3 cycles after out_valid=1 with out_data=0x55 → word and out_sel stable, in_ready=0. When out_ready=1, the next granted word appears on the following edge.
- Non-power-of-two CH=3, mode=1: channels 1 and 2 valid, ptr=2 → grants 2, then 1, then 2; ptr wraps 2→0 and never reaches 3.
- Reset mid-transfer: out_valid=1, out_ready=0, clrn=0 for 1 edge → out_valid=0, out_data=0, ptr=0. The next round-robin grant starts from channel 0.

Source files
------------

// File: rtl/mux_arb_nx.sv
`default_nettype none
// ============================================================================
//  Module   : mux_arb_nx
//  Purpose  : CH-to-1 valid/ready merge with fixed-priority or round-robin
//             arbitration and a one-entry output register with back-pressure.
//  Revision : 1.0  initial release
// ============================================================================
module mux_arb_nx #(
  parameter  int WIDTH = 32,
  parameter  int CH    = 4,
  localparam int SELW  = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic                clk,
  input  logic                clrn,
  input  logic                mode,
  input  logic [CH-1:0]       in_valid,
  input  logic [CH*WIDTH-1:0] in_data,
  output logic [CH-1:0]       in_ready,
  output logic                out_valid,
  output logic [WIDTH-1:0]    out_data,
  output logic [SELW-1:0]     out_sel,
  input  logic                out_ready
);

  logic [SELW-1:0]  ptr;
  logic [SELW-1:0]  start;
  logic [SELW-1:0]  next_ptr;
  logic [CH-1:0]    grant;
  logic [SELW-1:0]  grant_sel;
  logic [WIDTH-1:0] grant_data;
  logic             grant_any;
  logic             load;

  // The register can take a word when empty or being drained this cycle.
  assign load     = clrn & (~out_valid | out_ready);
  // Fixed priority is simply a round-robin search anchored at channel 0.
  assign start    = mode ? ptr : '0;
  assign in_ready = {CH{load}} & grant;
  // Pointer wraps at the last real channel, not at the index field width.
  assign next_ptr = (grant_sel == SELW'(CH - 1)) ? '0 : grant_sel + SELW'(1);

  // Circular priority search: channels start..CH-1 first, then 0..start-1.
  always_comb begin
    grant      = '0;
    grant_sel  = '0;
    grant_data = '0;
    grant_any  = 1'b0;
    for (int i = 0; i < CH; i++) begin
      if (!grant_any && in_valid[i] && (i >= int'(start))) begin
        grant_any  = 1'b1;
        grant[i]   = 1'b1;
        grant_sel  = SELW'(i);
        grant_data = in_data[i*WIDTH +: WIDTH];
      end
    end
    for (int i = 0; i < CH; i++) begin
      if (!grant_any && in_valid[i]) begin
        grant_any  = 1'b1;
        grant[i]   = 1'b1;
        grant_sel  = SELW'(i);
        grant_data = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Output register and round-robin pointer; a stalled word holds stable.
  always_ff @(posedge clk) begin
    if (!clrn) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      ptr       <= '0;
    end else if (load) begin
      if (grant_any) begin
        out_valid <= 1'b1;
        out_data  <= grant_data;
        out_sel   <= grant_sel;
        if (mode) begin
          ptr <= next_ptr;
        end
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mux_arb_nx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mux_arb_nx
//  Purpose  : Randomised scoreboard bench for mux_arb_nx, exercising a CH=4
//             and a CH=3 instance side by side against a behavioural model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mux_arb_nx;

  logic        clk = 1'b0;
  logic        clrn;
  logic        mode;
  logic        out_ready;
  logic [3:0]  iv0;
  logic [31:0] id0;
  logic [2:0]  iv1;
  logic [23:0] id1;
  logic [3:0]  ir0;
  logic [2:0]  ir1;
  logic        ov0, ov1;
  logic [7:0]  od0, od1;
  logic [1:0]  os0, os1;

  int checks = 0;
  int passes = 0;
  int pv     = 0;
  int pr     = 100;

  // Model state per instance (0: CH=4, 1: CH=3); entries are {sel, data}.
  int         mptr[2];
  bit         mvalid[2];
  logic [9:0] q0[$];
  logic [9:0] q1[$];
  bit         push;
  logic [9:0] ent;

  // Monitor state
  bit         last_clrn = 1'b1;
  bit         seen_rst  = 1'b0;
  bit         stall[2];
  logic [9:0] held[2];
  bit         pop;

  always #5 clk = ~clk;

  mux_arb_nx #(.WIDTH(8), .CH(4)) u_dut4 (
    .clk(clk), .clrn(clrn), .mode(mode), .in_valid(iv0), .in_data(id0),
    .in_ready(ir0), .out_valid(ov0), .out_data(od0), .out_sel(os0),
    .out_ready(out_ready)
  );

  mux_arb_nx #(.WIDTH(8), .CH(3)) u_dut3 (
    .clk(clk), .clrn(clrn), .mode(mode), .in_valid(iv1), .in_data(id1),
    .in_ready(ir1), .out_valid(ov1), .out_data(od1), .out_sel(os1),
    .out_ready(out_ready)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Behavioural model: circular search from the pointer, modulo channel count.
  task automatic model_step(input int u, input int nch, input logic [3:0] iv,
                            input logic [31:0] id, input logic [3:0] ir,
                            output bit psh, output logic [9:0] e);
    int  g;
    int  base;
    bit  ld;
    logic [3:0] exp_rdy;
    psh = 1'b0; e = '0; g = -1; exp_rdy = '0;
    if (!clrn) begin
      mvalid[u] = 1'b0;
      mptr[u]   = 0;
      check($sformatf("in_ready_rst[%0d]", u), {28'h0, ir}, 32'h0);
    end else begin
      ld   = !mvalid[u] || out_ready;
      base = mode ? mptr[u] : 0;
      for (int k = 0; k < nch; k++)
        if (g < 0 && iv[(base + k) % nch]) g = (base + k) % nch;
      if (ld && g >= 0) exp_rdy = 4'(1) << g;
      check($sformatf("in_ready[%0d]", u), {28'h0, ir}, {28'h0, exp_rdy});
      if (ld) begin
        if (g >= 0) begin
          psh = 1'b1;
          e   = {2'(g), id[g*8 +: 8]};
          mvalid[u] = 1'b1;
          if (mode) mptr[u] = (g + 1) % nch;
        end else begin
          mvalid[u] = 1'b0;
        end
      end
    end
  endtask

  // Per-instance output checks: reset values, occupancy, stall hold, handshake data.
  task automatic mon_step(input int u, input logic v, input logic [7:0] d,
                          input logic [1:0] s, input int qn, input logic [9:0] front,
                          output bit pp);
    pp = 1'b0;
    if (seen_rst) begin
      if (!last_clrn) begin
        check($sformatf("rst_valid[%0d]", u), {31'h0, v}, 32'h0);
        check($sformatf("rst_data[%0d]", u), {24'h0, d}, 32'h0);
        check($sformatf("rst_sel[%0d]", u), {30'h0, s}, 32'h0);
      end
      check($sformatf("valid[%0d]", u), {31'h0, v}, {31'h0, (qn != 0)});
      if (stall[u]) begin
        check($sformatf("hold_data[%0d]", u), {24'h0, d}, {24'h0, held[u][7:0]});
        check($sformatf("hold_sel[%0d]", u), {30'h0, s}, {30'h0, held[u][9:8]});
      end
      if (clrn && v && out_ready && qn != 0) begin
        pp = 1'b1;
        check($sformatf("out_data[%0d]", u), {24'h0, d}, {24'h0, front[7:0]});
        check($sformatf("out_sel[%0d]", u), {30'h0, s}, {30'h0, front[9:8]});
      end
    end
    stall[u] = clrn && v && !out_ready;
    held[u]  = {s, d};
  endtask

  // Monitor: samples outputs on the falling edge and retires scoreboard entries.
  initial begin
    forever begin
      @(negedge clk);
      mon_step(0, ov0, od0, os0, q0.size(), (q0.size() != 0) ? q0[0] : 10'h0, pop);
      if (pop) void'(q0.pop_front());
      mon_step(1, ov1, od1, os1, q1.size(), (q1.size() != 0) ? q1[0] : 10'h0, pop);
      if (pop) void'(q1.pop_front());
      if (!clrn) seen_rst = 1'b1;
      last_clrn = clrn;
    end
  end

  // Predictor: runs just after the monitor, pushes the word the next edge loads.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      model_step(0, 4, iv0, id0, ir0, push, ent);
      if (!clrn) q0.delete();
      if (push) q0.push_back(ent);
      model_step(1, 3, {1'b0, iv1}, {8'h0, id1}, {1'b0, ir1}, push, ent);
      if (!clrn) q1.delete();
      if (push) q1.push_back(ent);
    end
  end

  // One clock of stimulus: requests persist until accepted, then are redrawn.
  task automatic cycle();
    logic [3:0] a0;
    logic [2:0] a1;
    @(negedge clk);
    a0 = iv0 & ir0;
    a1 = iv1 & ir1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      if (!iv0[i] || a0[i]) begin
        iv0[i]         = int'($urandom_range(99)) < pv;
        id0[i*8 +: 8]  = 8'($urandom);
      end
    end
    for (int i = 0; i < 3; i++) begin
      if (!iv1[i] || a1[i]) begin
        iv1[i]         = int'($urandom_range(99)) < pv;
        id1[i*8 +: 8]  = 8'($urandom);
      end
    end
    out_ready = int'($urandom_range(99)) < pr;
  endtask

  // Test sequence
  initial begin
    clrn = 1'b0; mode = 1'b0; out_ready = 1'b1;
    iv0 = '0; id0 = '0; iv1 = '0; id1 = '0;
    mptr[0] = 0; mptr[1] = 0; mvalid[0] = 1'b0; mvalid[1] = 1'b0;
    stall[0] = 1'b0; stall[1] = 1'b0;
    pv = 0; pr = 100;
    repeat (2) cycle();
    clrn = 1'b1;
    repeat (3) cycle();                         // idle after reset
    mode = 1'b0; pv = 100; pr = 100;
    repeat (8) cycle();                         // fixed priority, saturated
    mode = 1'b1;
    repeat (12) cycle();                        // round-robin, saturated
    pr = 30;
    repeat (40) cycle();                        // heavy back-pressure
    pv = 60; pr = 60;
    repeat (300) cycle();                       // round-robin, random traffic
    pv = 100; pr = 0;
    repeat (4) cycle();                         // stall with a held word
    clrn = 1'b0;
    cycle();                                    // reset mid-stall
    clrn = 1'b1; pr = 100;
    repeat (10) cycle();
    mode = 1'b0; pv = 50; pr = 70;
    repeat (200) cycle();                       // fixed priority, random traffic
    repeat (300) begin                          // mode flipping every cycle
      mode = 1'($urandom_range(1));
      pv   = int'($urandom_range(100));
      pr   = int'($urandom_range(100));
      cycle();
    end
    pv = 0; pr = 100;
    repeat (4) cycle();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire
